uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte-oriented UART transmitter with a small input FIFO.
- Drives the board `tx` pin, so game logic can send event and status bytes (shots, hits, positions) to a host.
- Counterpart of the host-to-board serial direction on `rx`.
- Sits beside the VGA and game-control logic in `top`, in the same `clk` domain; the game pushes bytes with a valid/ready handshake and never waits on the serial rate unless the FIFO is full.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 104 at defaults), must be >= 2.
- FIFO_DEPTH, 4, byte entries in the input FIFO; power of 2, >= 2.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid & in_ready at a rising edge.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high while the FIFO is non-empty or a frame is on the line.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values, while rst is high and on the cycle it is sampled: tx=1, in_ready=0, busy=0, FIFO empty, FSM in IDLE, bit counter 0, baud counter 0.
  - in_ready rises on the first edge after rst is low.
- Reset mid-frame:
  - The frame is abandoned; tx returns to 1 on the reset edge.
  - All queued bytes are discarded; no partial byte is resent.
- FIFO:
  - in_ready = not full.
  - A write when not full stores in_data.
  - in_valid while full has no effect, and the byte is not stored.
  - A simultaneous push and pop is allowed whenever not full; occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; full/empty come from an occupancy counter of log2(FIFO_DEPTH)+1 bits.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, drive tx=0 and go to START. The baud counter loads CLKS_PER_BIT-1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end:
    - If the FIFO is non-empty, pop and go directly to START; there is no idle gap and the next start bit begins on the cycle after the last stop cycle.
    - Otherwise go to IDLE.
- Timing:
  - A byte accepted into an empty FIFO with the FSM in IDLE at edge N pops at edge N+1; tx falls at edge N+1.
  - Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles, 1040 at defaults.
- Baud counter:
  - Down-counter of width clog2(STOP_BITS*CLKS_PER_BIT).
  - Reloads at every bit boundary; a bit ends when the counter is 0.
- busy = (occupancy != 0) | (state != IDLE), registered, consistent with the state on the same edge.
- in_data is sampled only at the accepting edge; later changes do not affect the queued byte.

Decomposition:
- uart_pkg:
  - Function computing CLKS_PER_BIT from CLK_HZ and BAUD.
  - FSM state encoding constants: IDLE=0, START=1, DATA=2, STOP=3.
  - Frame-length helper shared with a future receiver.
- Sub-module byte_fifo (parameter DEPTH):
  - Ports: clk, rst, wr_en, wr_data[7:0], rd_en, rd_data[7:0], full, empty.
  - Show-ahead read: rd_data is valid whenever not empty.
- uart_tx_fifo instantiates byte_fifo and contains the FSM, baud counter and shift register.

Test Plan:
- CLK_HZ=1000, BAUD=100 (10 clk/bit); push 0x55 at edge N -> tx falls at N+1, then line pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop) each 10 cycles; busy drops at N+101.
- Push 0xA5 then 0x3C on consecutive cycles -> second start bit immediately follows the first stop bit, total 200 busy cycles, decoded bytes 0xA5, 0x3C.
- Hold in_valid with bytes 0x01..0x06 from reset -> 5 accepted (1 popped into shifter + 4 queued); in_ready low from the 5th accept until the first frame ends; 6th byte accepted exactly then; all six transmitted in order.
- Assert rst during DATA bit 3 of 0xF0, with 2 bytes queued -> tx=1 on the reset edge, busy=0, nothing transmitted afterwards until a new push.
- Defaults (12 MHz, 115200): push 0x00 -> tx low for exactly 9*104=936 cycles, then high 104 cycles; busy high for 1040 cycles.
- STOP_BITS=2, 10 clk/bit, two back-to-back bytes -> 20 stop cycles between frames; frame length 110 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period math, transmitter state encoding and frame length.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Clock cycles from the start-bit edge to the end of the last stop bit.
    function automatic int unsigned frame_clks(input int unsigned cpb, input int unsigned stop_bits);
        return (9 + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with show-ahead read; full/empty derived from an occupancy counter.
module byte_fifo import uart_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1/8N2) fed by a small byte FIFO with a valid/ready push interface.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned CPB       = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned STOP_CLKS = STOP_BITS * CPB;
    localparam int unsigned CNT_W     = $clog2(STOP_CLKS);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_CLKS - 1);

    tx_state_e         state;
    tx_state_e         state_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_d;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] shift_d;
    logic              tx_d;
    logic              pop;
    logic              ready_en;
    logic              wr_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_rd_data;

    // ready_en keeps in_ready low through reset and releases it on the first edge after.
    assign in_ready = ready_en & ~fifo_full;
    assign wr_en    = in_valid & in_ready;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!fifo_empty) state_d = START;
            START:   if (cnt == '0) state_d = DATA;
            DATA:    if (cnt == '0 && bit_idx == 3'd7) state_d = STOP;
            STOP:    if (cnt == '0) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; a pop always coincides with driving the start bit.
    always_comb begin
        pop       = 1'b0;
        tx_d      = tx;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    tx_d    = 1'b0;
                    cnt_d   = BIT_RELOAD;
                end
            end
            START: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    tx_d      = shift[0];
                    bit_idx_d = 3'd0;
                    cnt_d     = BIT_RELOAD;
                end
            end
            DATA: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    if (bit_idx == 3'd7) begin
                        tx_d  = 1'b1;
                        cnt_d = STOP_RELOAD;
                    end else begin
                        shift_d   = shift >> 1;
                        tx_d      = shift[1];
                        bit_idx_d = bit_idx + 3'd1;
                        cnt_d     = BIT_RELOAD;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    tx_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        tx_d    = 1'b0;
                        cnt_d   = BIT_RELOAD;
                    end
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    // busy looks ahead one edge so it tracks the FIFO occupancy and state being registered now.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            busy     <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            tx       <= tx_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            busy     <= (state_d != IDLE) | wr_en | ~fifo_empty;
            ready_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued and a monitor checks the line cycle by cycle.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned BAUD      = 100;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned STOP_BITS = 1;
    localparam int          CPB       = int'(CLK_HZ / BAUD);
    localparam int          FRAME     = (9 + int'(STOP_BITS)) * CPB;

    typedef struct {
        logic [7:0]  data;
        int unsigned edge_no;
    } item_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic       tx;
    logic       busy;

    int unsigned cyc       = 0;
    logic        rst_seen  = 1'b0;
    bit          armed     = 1'b0;
    item_t       exp_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          frame_pos = -1;
    item_t       cur;
    logic [7:0]  dec;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (STOP_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endfunction

    // Expected line level at a given position inside a frame (negative = no frame).
    function automatic logic line_bit(input logic [7:0] b, input int pos);
        int k;
        if (pos < 0) return 1'b1;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Monitor: pops a byte when a frame must start and checks tx, busy, in_ready every cycle.
    always @(negedge clk) begin
        int k;
        if (rst_seen) armed = 1'b1;
        if (armed) begin
            if (rst_seen) begin
                exp_q.delete();
                frame_pos = -1;
                chk("reset_tx", 32'(tx), 32'(1));
                chk("reset_busy", 32'(busy), 32'(0));
                chk("reset_in_ready", 32'(in_ready), 32'(0));
            end else begin
                if (frame_pos >= 0) begin
                    frame_pos++;
                    if (frame_pos == FRAME) frame_pos = -1;
                end
                if (frame_pos < 0 && exp_q.size() != 0 && exp_q[0].edge_no < cyc) begin
                    cur       = exp_q.pop_front();
                    frame_pos = 0;
                    dec       = 8'h00;
                end
                chk("tx_line", 32'(tx), 32'(line_bit(cur.data, frame_pos)));
                if (frame_pos >= 0) begin
                    k = frame_pos / CPB;
                    if (k >= 1 && k <= 8 && (frame_pos % CPB) == CPB / 2) dec = {tx, dec[7:1]};
                    if (frame_pos == FRAME - 1) chk("decoded_byte", 32'(dec), 32'(cur.data));
                end
                chk("busy", 32'(busy), 32'(exp_q.size() != 0 || frame_pos >= 0));
                chk("in_ready", 32'(in_ready), 32'(exp_q.size() < int'(DEPTH)));
            end
        end
    end

    // One cycle of stimulus; records the byte in the scoreboard if it will be accepted.
    task automatic step(input logic v, input logic [7:0] d, input logic r, output logic acc);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        rst      = r;
        #1;
        acc = v && in_ready && !r;
        if (acc) exp_q.push_back('{data: d, edge_no: cyc + 1});
    endtask

    task automatic push_byte(input logic [7:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 3000) begin
            step(1'b1, d, 1'b0, acc);
            n++;
        end
        chk("push_accept", 32'(acc), 32'(1));
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, acc);
    endtask

    task automatic reset_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        idle(1);
        while ((busy || exp_q.size() != 0 || frame_pos >= 0) && n < 20000) begin
            idle(1);
            n++;
        end
        chk("drain_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int          rate;
        logic        acc;

        reset_cycles(3);
        idle(5);

        // Single byte, then two back-to-back bytes.
        push_byte(8'h55);
        wait_idle();
        push_byte(8'hA5);
        push_byte(8'h3C);
        wait_idle();

        // Continuous valid straight out of reset fills the FIFO and stalls.
        reset_cycles(2);
        for (int b = 1; b <= 6; b++) push_byte(8'(b));
        wait_idle();

        // Reset during data bit 3 of 0xF0 with two bytes queued behind it.
        push_byte(8'hF0);
        base = cyc;
        push_byte(8'h11);
        push_byte(8'h22);
        while (cyc + 1 < base + 1 + 3 * 10 + 15) idle(1);
        reset_cycles(1);
        idle(200);
        push_byte(8'h81);
        wait_idle();

        // Randomized traffic with varying load and occasional resets.
        rate = 30;
        for (int i = 0; i < 6000; i++) begin
            if (i % 300 == 0) begin
                case ($urandom_range(0, 3))
                    0:       rate = 5;
                    1:       rate = 30;
                    2:       rate = 90;
                    default: rate = 100;
                endcase
            end
            if ($urandom_range(0, 1499) == 0)
                step(1'b0, 8'h00, 1'b1, acc);
            else
                step(1'($urandom_range(0, 99) < rate), 8'($urandom), 1'b0, acc);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
